// File: rtl/pe_pkg.sv
// Shared types and constants for the priority-evaluator scanline sequencer.
// The optional single-fetch path is controlled by the PE_SKIP_FETCH2_EN macro.
package pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_LAYERS,
        ADDR1,
        DATA1,
        ADDR2,
        DATA2,
        EMIT,
        DONE
    } pe_seq_state_t;

    localparam int          NUM_COLS_DEF  = 240;
    localparam logic [7:0]  LAST_COL      = 8'(NUM_COLS_DEF - 1);
    localparam int          VISIBLE_LINES = 160;

    // PRAM is requested only while an address phase is being presented
    function automatic logic is_addr_state(input pe_seq_state_t s);
        return (s == ADDR1) || (s == ADDR2);
    endfunction

endpackage

// File: rtl/pe_col_counter.sv
// Column index counter for the scanline sequencer: saturates at LAST so the
// evaluator never sees a column beyond the visible width.
module pe_col_counter
    import pe_pkg::*;
#(
    parameter logic [7:0] LAST = LAST_COL
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       load_zero,
    input  logic       inc,
    output logic [7:0] count,
    output logic       at_last
);

    always_ff @(posedge clk) begin
        if (clear || load_zero) begin
            count <= 8'd0;
        end else if (inc && !at_last) begin
            count <= count + 8'd1;
        end
    end

    assign at_last = (count == LAST);

endmodule

// File: rtl/priority_eval_seq.sv
// Per-scanline sequencer driving the priority evaluator's palette fetch strobes.
// Build option PE_SKIP_FETCH2_EN: skip the second fetch when blend_needed is 0.
//
//   state       | meaning
//   ------------+-----------------------------------------------------
//   IDLE        | waiting for an accepted line_start
//   WAIT_LAYERS | waiting for BG/OBJ layer data of current col
//   ADDR1       | first palette address presented, PRAM requested
//   DATA1       | first palette read data captured
//   ADDR2       | second palette address presented, PRAM requested
//   DATA2       | second palette read data captured
//   EMIT        | pixel offered to the blender
//   DONE        | line finished, line_done pulse
module priority_eval_seq
    import pe_pkg::*;
#(
    parameter int NUM_COLS  = NUM_COLS_DEF,
    parameter int NUM_LINES = VISIBLE_LINES
) (
    input  logic       clk,
    input  logic       clear,
    input  logic       line_start,
    input  logic [7:0] vcount,
    input  logic       layers_valid,
    input  logic       pram_gnt,
    input  logic       pixel_ready,
    input  logic       blend_needed,
    output logic [7:0] col,
    output logic       send_address_1,
    output logic       send_address_2,
    output logic       read_data_1,
    output logic       read_data_2,
    output logic       pram_req,
    output logic       pixel_valid,
    output logic       line_done,
    output logic       busy,
    output logic       overrun
);

    localparam logic [7:0] COL_LAST     = 8'(NUM_COLS - 1);
    localparam logic [8:0] LINES_LIMIT  = 9'(NUM_LINES);

    pe_seq_state_t state;
    pe_seq_state_t next_state;

    logic line_ok;
    logic col_load;
    logic col_inc;
    logic col_at_last;

`ifndef PE_SKIP_FETCH2_EN
    logic unused_blend;
    assign unused_blend = blend_needed;
`endif

    assign line_ok = ({1'b0, vcount} < LINES_LIMIT);

    always_ff @(posedge clk) begin
        if (clear) begin
            state   <= IDLE;
            overrun <= 1'b0;
        end else begin
            state <= next_state;
            // Any line_start outside IDLE (DONE included) is dropped and flagged
            if (line_start && (state != IDLE)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        next_state     = state;
        send_address_1 = 1'b0;
        send_address_2 = 1'b0;
        read_data_1    = 1'b0;
        read_data_2    = 1'b0;
        pixel_valid    = 1'b0;
        line_done      = 1'b0;
        col_load       = 1'b0;
        col_inc        = 1'b0;

        unique case (state)
            IDLE: begin
                if (line_start && line_ok) begin
                    col_load   = 1'b1;
                    next_state = WAIT_LAYERS;
                end
            end
            WAIT_LAYERS: begin
                if (layers_valid) begin
                    next_state = ADDR1;
                end
            end
            ADDR1: begin
                send_address_1 = 1'b1;
                if (pram_gnt) begin
                    next_state = DATA1;
                end
            end
            DATA1: begin
                read_data_1 = 1'b1;
`ifdef PE_SKIP_FETCH2_EN
                next_state = blend_needed ? ADDR2 : EMIT;
`else
                next_state = ADDR2;
`endif
            end
            ADDR2: begin
                send_address_2 = 1'b1;
                if (pram_gnt) begin
                    next_state = DATA2;
                end
            end
            DATA2: begin
                read_data_2 = 1'b1;
                next_state  = EMIT;
            end
            EMIT: begin
                pixel_valid = 1'b1;
                if (pixel_ready) begin
                    if (col_at_last) begin
                        next_state = DONE;
                    end else begin
                        col_inc    = 1'b1;
                        next_state = WAIT_LAYERS;
                    end
                end
            end
            DONE: begin
                line_done  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    assign pram_req = is_addr_state(state);
    assign busy     = (state != IDLE);

    pe_col_counter #(
        .LAST (COL_LAST)
    ) u_col_counter (
        .clk       (clk),
        .clear     (clear),
        .load_zero (col_load),
        .inc       (col_inc),
        .count     (col),
        .at_last   (col_at_last)
    );

endmodule

// File: tb/tb_priority_eval_seq.sv
// Self-checking bench for priority_eval_seq: scoreboard of expected columns,
// per-scenario tasks for timing, stalls, overrun, clear and the skip option.
module tb_priority_eval_seq;

    logic       clk = 1'b0;
    logic       clear;
    logic       line_start;
    logic [7:0] vcount;
    logic       layers_valid;
    logic       pram_gnt;
    logic       pixel_ready;
    logic       blend_needed;
    logic [7:0] col;
    logic       send_address_1;
    logic       send_address_2;
    logic       read_data_1;
    logic       read_data_2;
    logic       pram_req;
    logic       pixel_valid;
    logic       line_done;
    logic       busy;
    logic       overrun;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         cyc_cnt  = 0;
    int         rd2_cnt  = 0;
    int         pv_cyc [256];
    logic [7:0] sb_q [$];

    always #5 clk = ~clk;

    priority_eval_seq dut (
        .clk            (clk),
        .clear          (clear),
        .line_start     (line_start),
        .vcount         (vcount),
        .layers_valid   (layers_valid),
        .pram_gnt       (pram_gnt),
        .pixel_ready    (pixel_ready),
        .blend_needed   (blend_needed),
        .col            (col),
        .send_address_1 (send_address_1),
        .send_address_2 (send_address_2),
        .read_data_1    (read_data_1),
        .read_data_2    (read_data_2),
        .pram_req       (pram_req),
        .pixel_valid    (pixel_valid),
        .line_done      (line_done),
        .busy           (busy),
        .overrun        (overrun)
    );

    always @(posedge clk) cyc_cnt++;

    // Monitor: strobe exclusivity every cycle, scoreboard pop on each handshake
    always @(negedge clk) begin
        logic [7:0] exp_col;
        n_checks++;
        if (($countones({send_address_1, send_address_2, read_data_1, read_data_2,
                         pixel_valid, line_done}) > 1) ||
            (pram_req !== (send_address_1 | send_address_2))) begin
            n_fail++;
            $display("FAIL strobe_excl t=%0t sa1=%b sa2=%b rd1=%b rd2=%b req=%b pv=%b ld=%b",
                     $time, send_address_1, send_address_2, read_data_1, read_data_2,
                     pram_req, pixel_valid, line_done);
        end
        if (read_data_2 === 1'b1) rd2_cnt++;
        if (pixel_valid === 1'b1 && pixel_ready === 1'b1) begin
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_pixel col=%0d required=none", col);
            end else begin
                exp_col = sb_q.pop_front();
                if (col !== exp_col) begin
                    n_fail++;
                    $display("FAIL sb_col actual=%0d required=%0d", col, exp_col);
                end
            end
            pv_cyc[col] = cyc_cnt;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_line(input logic [7:0] vc, input bit push);
        vcount     = vc;
        line_start = 1'b1;
        if (push) begin
            for (int c = 0; c < 240; c++) sb_q.push_back(8'(c));
        end
        for (int c = 0; c < 256; c++) pv_cyc[c] = 0;
        tick(1);
        line_start = 1'b0;
    endtask

    // kind: 0 line_done, 1 ADDR1 at col c, 2 ADDR2 at col c, 3 EMIT at col c, 4 col==c
    task automatic wait_for(input int kind, input int c, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            case (kind)
                0: ok = (line_done === 1'b1);
                1: ok = (send_address_1 === 1'b1) && (col == 8'(c));
                2: ok = (send_address_2 === 1'b1) && (col == 8'(c));
                3: ok = (pixel_valid === 1'b1) && (col == 8'(c));
                default: ok = (col == 8'(c));
            endcase
            if (ok) break;
            tick(1);
        end
    endtask

    task automatic test_reset();
        clear = 1'b1;
        tick(2);
        n_checks++;
        if ({send_address_1, send_address_2, read_data_1, read_data_2, pram_req,
             pixel_valid, line_done, busy, overrun} !== 9'b0 || col !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_state outputs=%b col=%0d required=0/0",
                     {send_address_1, send_address_2, read_data_1, read_data_2, pram_req,
                      pixel_valid, line_done, busy, overrun}, col);
        end
        clear = 1'b0;
        tick(1);
    endtask

    task automatic test_ideal_line();
        logic [5:0] exp_seq [1:7];
        int n, pv_count, last, bad_gap;
        exp_seq[1] = 6'b000000;
        exp_seq[2] = 6'b100010;
        exp_seq[3] = 6'b010000;
        exp_seq[4] = 6'b001010;
        exp_seq[5] = 6'b000100;
        exp_seq[6] = 6'b000001;
        exp_seq[7] = 6'b000000;
        layers_valid = 1'b1;
        pram_gnt     = 1'b1;
        pixel_ready  = 1'b1;
        blend_needed = 1'b1;
        start_line(8'd10, 1'b1);
        n_checks++;
        if (busy !== 1'b1 || col !== 8'd0) begin
            n_fail++;
            $display("FAIL ideal_wait_entry busy=%b col=%0d required=1/0", busy, col);
        end
        n = 1; pv_count = 0; last = -1; bad_gap = 0;
        while (line_done !== 1'b1 && n < 2000) begin
            if (n <= 6) begin
                n_checks++;
                if ({send_address_1, read_data_1, send_address_2, read_data_2, pram_req,
                     pixel_valid} !== exp_seq[n]) begin
                    n_fail++;
                    $display("FAIL ideal_seq cycle=%0d actual=%b required=%b", n,
                             {send_address_1, read_data_1, send_address_2, read_data_2,
                              pram_req, pixel_valid}, exp_seq[n]);
                end
            end
            if (pixel_valid === 1'b1) begin
                pv_count++;
                if (last >= 0 && n - last != 6) bad_gap++;
                last = n;
            end
            tick(1);
            n++;
        end
        n_checks++;
        if (n != 1441) begin
            n_fail++;
            $display("FAIL ideal_line_done_cycle actual=%0d required=1441", n);
        end
        n_checks++;
        if (pv_count != 240 || bad_gap != 0) begin
            n_fail++;
            $display("FAIL ideal_pixels count=%0d bad_gaps=%0d required=240/0", pv_count, bad_gap);
        end
        n_checks++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL ideal_sb_left actual=%0d required=0", sb_q.size());
        end
        tick(1);
        n_checks++;
        if (busy !== 1'b0 || line_done !== 1'b0 || col !== 8'd239) begin
            n_fail++;
            $display("FAIL ideal_after busy=%b ld=%b col=%0d required=0/0/239", busy, line_done, col);
        end
    endtask

    task automatic test_grant_stall();
        bit ok;
        int sa_cnt, hold_bad;
        start_line(8'd11, 1'b1);
        wait_for(1, 5, 200, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL stall_reach_addr1 actual=timeout required=col5");
        end
        pram_gnt = 1'b0;
        sa_cnt = 0; hold_bad = 0;
        while (send_address_1 === 1'b1 && sa_cnt < 20) begin
            sa_cnt++;
            if (pram_req !== 1'b1 || col !== 8'd5 || read_data_1 !== 1'b0) hold_bad++;
            if (sa_cnt == 4) pram_gnt = 1'b1;
            tick(1);
        end
        n_checks++;
        if (sa_cnt != 4 || hold_bad != 0) begin
            n_fail++;
            $display("FAIL stall_addr1_hold cycles=%0d bad=%0d required=4/0", sa_cnt, hold_bad);
        end
        n_checks++;
        if (read_data_1 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_rd1 actual=%b required=1", read_data_1);
        end
        tick(1);
        n_checks++;
        if (read_data_1 !== 1'b0 || send_address_2 !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_rd1_once rd1=%b sa2=%b required=0/1", read_data_1, send_address_2);
        end
        wait_for(0, 0, 2000, ok);
        n_checks++;
        if (!ok || pv_cyc[5] - pv_cyc[4] != 9 || pv_cyc[6] - pv_cyc[5] != 6) begin
            n_fail++;
            $display("FAIL stall_period done=%b p5=%0d p6=%0d required=1/9/6", ok,
                     pv_cyc[5] - pv_cyc[4], pv_cyc[6] - pv_cyc[5]);
        end
        tick(1);
    endtask

    task automatic test_backpressure();
        bit ok;
        int bad;
        start_line(8'd12, 1'b1);
        wait_for(3, 239, 2000, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL bp_reach_last actual=timeout required=col239");
        end
        pixel_ready = 1'b0;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (pixel_valid !== 1'b1 || col !== 8'd239 || line_done !== 1'b0) bad++;
            tick(1);
        end
        n_checks++;
        if (bad != 0 || pixel_valid !== 1'b1 || line_done !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_hold bad=%0d pv=%b ld=%b required=0/1/0", bad, pixel_valid, line_done);
        end
        pixel_ready = 1'b1;
        tick(1);
        n_checks++;
        if (line_done !== 1'b1 || sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_line_done ld=%b sb_left=%0d required=1/0", line_done, sb_q.size());
        end
        // line_start landing on the DONE cycle is dropped and flagged
        vcount     = 8'd5;
        line_start = 1'b1;
        tick(1);
        line_start = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b1 || line_done !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_start_on_done busy=%b ovr=%b ld=%b required=0/1/0", busy, overrun, line_done);
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        n_checks++;
        if (overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_overrun_clear actual=%b required=0", overrun);
        end
    endtask

    task automatic test_overrun_vblank();
        bit ok;
        start_line(8'd20, 1'b1);
        wait_for(4, 50, 2000, ok);
        vcount     = 8'd30;
        line_start = 1'b1;
        tick(1);
        line_start = 1'b0;
        n_checks++;
        if (!ok || overrun !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_set reached=%b ovr=%b busy=%b required=1/1/1", ok, overrun, busy);
        end
        wait_for(0, 0, 2000, ok);
        n_checks++;
        if (!ok || sb_q.size() != 0 || col !== 8'd239) begin
            n_fail++;
            $display("FAIL ovr_line_complete done=%b sb_left=%0d col=%0d required=1/0/239",
                     ok, sb_q.size(), col);
        end
        tick(1);
        n_checks++;
        if (overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL ovr_sticky actual=%b required=1", overrun);
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        start_line(8'd160, 1'b0);
        n_checks++;
        if (busy !== 1'b0 || overrun !== 1'b0 || col !== 8'd0) begin
            n_fail++;
            $display("FAIL vblank_ignored busy=%b ovr=%b col=%0d required=0/0/0", busy, overrun, col);
        end
        start_line(8'd159, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL last_visible_accepted busy=%b required=1", busy);
        end
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic test_clear_midline();
        bit ok;
        start_line(8'd40, 1'b1);
        wait_for(2, 100, 2000, ok);
        rd2_cnt = 0;
        clear   = 1'b1;
        tick(1);
        n_checks++;
        if (!ok || {send_address_1, send_address_2, read_data_1, read_data_2, pram_req,
                    pixel_valid, line_done, busy, overrun} !== 9'b0 || col !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_midline reached=%b outputs=%b col=%0d required=1/0/0", ok,
                     {send_address_1, send_address_2, read_data_1, read_data_2, pram_req,
                      pixel_valid, line_done, busy, overrun}, col);
        end
        clear = 1'b0;
        sb_q.delete();
        tick(3);
        n_checks++;
        if (rd2_cnt != 0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_no_rd2 rd2=%0d busy=%b required=0/0", rd2_cnt, busy);
        end
    endtask

    task automatic test_skip_fetch();
        bit ok;
`ifdef PE_SKIP_FETCH2_EN
        blend_needed = 1'b0;
        rd2_cnt = 0;
        start_line(8'd50, 1'b1);
        wait_for(0, 0, 2000, ok);
        n_checks++;
        if (!ok || pv_cyc[1] - pv_cyc[0] != 4 || pv_cyc[239] - pv_cyc[238] != 4 || rd2_cnt != 0) begin
            n_fail++;
            $display("FAIL skip_period done=%b p=%0d/%0d rd2=%0d required=1/4/4/0", ok,
                     pv_cyc[1] - pv_cyc[0], pv_cyc[239] - pv_cyc[238], rd2_cnt);
        end
        tick(1);
`endif
        // Without the skip option blend_needed=0 must still produce two fetches
        blend_needed = `ifdef PE_SKIP_FETCH2_EN 1'b1 `else 1'b0 `endif;
        rd2_cnt = 0;
        start_line(8'd51, 1'b1);
        wait_for(0, 0, 2000, ok);
        n_checks++;
        if (!ok || pv_cyc[1] - pv_cyc[0] != 6 || pv_cyc[239] - pv_cyc[238] != 6 || rd2_cnt != 240) begin
            n_fail++;
            $display("FAIL two_fetch_period done=%b p=%0d/%0d rd2=%0d required=1/6/6/240", ok,
                     pv_cyc[1] - pv_cyc[0], pv_cyc[239] - pv_cyc[238], rd2_cnt);
        end
        tick(1);
    endtask

    initial begin
        clear        = 1'b1;
        line_start   = 1'b0;
        vcount       = 8'd0;
        layers_valid = 1'b0;
        pram_gnt     = 1'b0;
        pixel_ready  = 1'b0;
        blend_needed = 1'b0;
        test_reset();
        test_ideal_line();
        test_grant_stall();
        test_backpressure();
        test_overrun_vblank();
        test_clear_midline();
        test_skip_fetch();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
